// File: rtl/intra_ref_buf_arb.sv
// Intra reference-pixel buffer: row/col/frame single-port SRAM banks behind posted-write
// buffers, with Y/U/V plane remapping, read forwarding from pending writes and backpressure.

module intra_ref_buf_bank #(
    parameter int A     = 8,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    sel_i,
    input  logic          wr_ena_i,
    input  logic [A-1:0]  wr_adr_i,
    input  logic [DW-1:0] wr_dat_i,
    output logic          wr_rdy_o,
    input  logic          rd_ena_i,
    input  logic [A-1:0]  rd_adr_i,
    output logic          rd_rdy_o,
    output logic [DW-1:0] rd_dat_o,
    output logic          rd_vld_o,
    output logic          empty_o
);
    localparam int PA = A + 1;
    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic [PA-1:0] remap(input logic [1:0] sel, input logic [A-1:0] adr);
        case (sel)
            2'd0:    remap = {1'b0, adr};
            2'd1:    remap = {3'b100, adr[A-3:0]};
            2'd2:    remap = {3'b101, adr[A-3:0]};
            default: remap = '0;
        endcase
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PA-1:0] adr_q [DEPTH];
    logic [PA-1:0] adr_d [DEPTH];
    logic [DW-1:0] dat_q [DEPTH];
    logic [DW-1:0] dat_d [DEPTH];
    logic [DW-1:0] mem_q [2**PA];
    logic [DW-1:0] sram_dat_q, fwd_dat_q, hit_dat;
    logic          fwd_q, rd_vld_q, hit;
    logic          full, rd_acc, wr_acc, drain;
    logic [PA-1:0] rd_pa, wr_pa;

    assign rd_pa  = remap(sel_i, rd_adr_i);
    assign wr_pa  = remap(sel_i, wr_adr_i);
    assign full   = (cnt_q == CW'(DEPTH));
    assign rd_acc = rd_ena_i & ~full;
    assign wr_acc = wr_ena_i & ~full;
    // Single port: a full buffer always wins the port, otherwise reads take priority.
    assign drain  = full | (~rd_ena_i & (cnt_q != '0));

    // Entry 0 is the oldest; a later index overrides, so the youngest match wins.
    always_comb begin
        hit     = 1'b0;
        hit_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && (adr_q[i] == rd_pa)) begin
                hit     = 1'b1;
                hit_dat = dat_q[i];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (drain) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                adr_d[i] = adr_q[i+1];
                dat_d[i] = dat_q[i+1];
            end
            cnt_d = cnt_q - 1'b1;
        end
        if (wr_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == cnt_d) begin
                    adr_d[i] = wr_pa;
                    dat_d[i] = wr_dat_i;
                end
            end
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            adr_q      <= '{default: '0};
            dat_q      <= '{default: '0};
            rd_vld_q   <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_dat_q  <= '0;
            sram_dat_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rd_vld_q <= rd_acc;
            if (rd_acc) begin
                fwd_q <= hit;
                if (hit) fwd_dat_q <= hit_dat;
                else     sram_dat_q <= mem_q[rd_pa];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (drain) mem_q[adr_q[0]] <= dat_q[0];
    end

    // Both data sources only change on an accepted read, so rd_dat holds between pulses.
    assign rd_dat_o = fwd_q ? fwd_dat_q : sram_dat_q;
    assign rd_vld_o = rd_vld_q;
    assign rd_rdy_o = ~full;
    assign wr_rdy_o = ~full;
    assign empty_o  = (cnt_q == '0);
endmodule

module intra_ref_buf_arb #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int RC_ADR_W     = 8,
    parameter int FRA_ADR_W    = 12,
    parameter int WBUF_DEPTH   = 2,
    localparam int DW          = PIXEL_WIDTH * PIX_PER_WORD
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           sel_i,
    input  logic                 wr_ena_row_i,
    input  logic                 wr_ena_col_i,
    input  logic                 wr_ena_fra_i,
    output logic                 wr_rdy_row_o,
    output logic                 wr_rdy_col_o,
    output logic                 wr_rdy_fra_o,
    input  logic [RC_ADR_W-1:0]  wr_adr_row_i,
    input  logic [RC_ADR_W-1:0]  wr_adr_col_i,
    input  logic [FRA_ADR_W-1:0] wr_adr_fra_i,
    input  logic [DW-1:0]        wr_dat_row_i,
    input  logic [DW-1:0]        wr_dat_col_i,
    input  logic [DW-1:0]        wr_dat_fra_i,
    input  logic                 rd_ena_row_i,
    input  logic                 rd_ena_col_i,
    input  logic                 rd_ena_fra_i,
    output logic                 rd_rdy_row_o,
    output logic                 rd_rdy_col_o,
    output logic                 rd_rdy_fra_o,
    input  logic [RC_ADR_W-1:0]  rd_adr_row_i,
    input  logic [RC_ADR_W-1:0]  rd_adr_col_i,
    input  logic [FRA_ADR_W-1:0] rd_adr_fra_i,
    output logic [DW-1:0]        rd_dat_row_o,
    output logic [DW-1:0]        rd_dat_col_o,
    output logic [DW-1:0]        rd_dat_fra_o,
    output logic                 rd_vld_row_o,
    output logic                 rd_vld_col_o,
    output logic                 rd_vld_fra_o,
    output logic                 idle_o
);
    logic empty_row, empty_col, empty_fra;

    intra_ref_buf_bank #(.A(RC_ADR_W), .DW(DW), .DEPTH(WBUF_DEPTH)) u_row (
        .clk(clk), .rstn(rstn), .sel_i(sel_i),
        .wr_ena_i(wr_ena_row_i), .wr_adr_i(wr_adr_row_i), .wr_dat_i(wr_dat_row_i), .wr_rdy_o(wr_rdy_row_o),
        .rd_ena_i(rd_ena_row_i), .rd_adr_i(rd_adr_row_i), .rd_rdy_o(rd_rdy_row_o),
        .rd_dat_o(rd_dat_row_o), .rd_vld_o(rd_vld_row_o), .empty_o(empty_row)
    );

    intra_ref_buf_bank #(.A(RC_ADR_W), .DW(DW), .DEPTH(WBUF_DEPTH)) u_col (
        .clk(clk), .rstn(rstn), .sel_i(sel_i),
        .wr_ena_i(wr_ena_col_i), .wr_adr_i(wr_adr_col_i), .wr_dat_i(wr_dat_col_i), .wr_rdy_o(wr_rdy_col_o),
        .rd_ena_i(rd_ena_col_i), .rd_adr_i(rd_adr_col_i), .rd_rdy_o(rd_rdy_col_o),
        .rd_dat_o(rd_dat_col_o), .rd_vld_o(rd_vld_col_o), .empty_o(empty_col)
    );

    intra_ref_buf_bank #(.A(FRA_ADR_W), .DW(DW), .DEPTH(WBUF_DEPTH)) u_fra (
        .clk(clk), .rstn(rstn), .sel_i(sel_i),
        .wr_ena_i(wr_ena_fra_i), .wr_adr_i(wr_adr_fra_i), .wr_dat_i(wr_dat_fra_i), .wr_rdy_o(wr_rdy_fra_o),
        .rd_ena_i(rd_ena_fra_i), .rd_adr_i(rd_adr_fra_i), .rd_rdy_o(rd_rdy_fra_o),
        .rd_dat_o(rd_dat_fra_o), .rd_vld_o(rd_vld_fra_o), .empty_o(empty_fra)
    );

    assign idle_o = empty_row & empty_col & empty_fra;
endmodule

// File: tb/tb_intra_ref_buf_arb.sv
// Directed bench for intra_ref_buf_arb: read expectations are queued per bank at drive
// time and checked (data and one-cycle latency) when rd_vld pulses.

module tb_intra_ref_buf_arb;
    logic        clk, rstn;
    logic [1:0]  sel;
    logic        wr_ena_row, wr_ena_col, wr_ena_fra;
    logic        wr_rdy_row, wr_rdy_col, wr_rdy_fra;
    logic [7:0]  wr_adr_row, wr_adr_col;
    logic [11:0] wr_adr_fra;
    logic [31:0] wr_dat_row, wr_dat_col, wr_dat_fra;
    logic        rd_ena_row, rd_ena_col, rd_ena_fra;
    logic        rd_rdy_row, rd_rdy_col, rd_rdy_fra;
    logic [7:0]  rd_adr_row, rd_adr_col;
    logic [11:0] rd_adr_fra;
    logic [31:0] rd_dat_row, rd_dat_col, rd_dat_fra;
    logic        rd_vld_row, rd_vld_col, rd_vld_fra;
    logic        idle;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t q_row[$];
    exp_t q_col[$];
    exp_t q_fra[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    intra_ref_buf_arb dut (
        .clk(clk), .rstn(rstn), .sel_i(sel),
        .wr_ena_row_i(wr_ena_row), .wr_ena_col_i(wr_ena_col), .wr_ena_fra_i(wr_ena_fra),
        .wr_rdy_row_o(wr_rdy_row), .wr_rdy_col_o(wr_rdy_col), .wr_rdy_fra_o(wr_rdy_fra),
        .wr_adr_row_i(wr_adr_row), .wr_adr_col_i(wr_adr_col), .wr_adr_fra_i(wr_adr_fra),
        .wr_dat_row_i(wr_dat_row), .wr_dat_col_i(wr_dat_col), .wr_dat_fra_i(wr_dat_fra),
        .rd_ena_row_i(rd_ena_row), .rd_ena_col_i(rd_ena_col), .rd_ena_fra_i(rd_ena_fra),
        .rd_rdy_row_o(rd_rdy_row), .rd_rdy_col_o(rd_rdy_col), .rd_rdy_fra_o(rd_rdy_fra),
        .rd_adr_row_i(rd_adr_row), .rd_adr_col_i(rd_adr_col), .rd_adr_fra_i(rd_adr_fra),
        .rd_dat_row_o(rd_dat_row), .rd_dat_col_o(rd_dat_col), .rd_dat_fra_o(rd_dat_fra),
        .rd_vld_row_o(rd_vld_row), .rd_vld_col_o(rd_vld_col), .rd_vld_fra_o(rd_vld_fra),
        .idle_o(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) tick();
    endtask

    // One cycle on bank b (0 row, 1 col, 2 fra): ers/ews are the ready levels the
    // buffer occupancy implies; a read is only expected back when ers says it is accepted.
    task automatic step(input int b, input bit rd, input logic [11:0] ra, input logic [31:0] ex,
                        input bit wr, input logic [11:0] wa, input logic [31:0] wd,
                        input bit ers, input bit ews);
        exp_t e;
        e.dat = ex;
        e.cyc = cyc + 1;
        case (b)
            0: begin
                rd_ena_row = rd; rd_adr_row = ra[7:0];
                wr_ena_row = wr; wr_adr_row = wa[7:0]; wr_dat_row = wd;
                chk("row_rd_rdy", {31'b0, rd_rdy_row}, {31'b0, ers});
                chk("row_wr_rdy", {31'b0, wr_rdy_row}, {31'b0, ews});
                if (rd && ers) q_row.push_back(e);
            end
            1: begin
                rd_ena_col = rd; rd_adr_col = ra[7:0];
                wr_ena_col = wr; wr_adr_col = wa[7:0]; wr_dat_col = wd;
                chk("col_rd_rdy", {31'b0, rd_rdy_col}, {31'b0, ers});
                chk("col_wr_rdy", {31'b0, wr_rdy_col}, {31'b0, ews});
                if (rd && ers) q_col.push_back(e);
            end
            default: begin
                rd_ena_fra = rd; rd_adr_fra = ra;
                wr_ena_fra = wr; wr_adr_fra = wa; wr_dat_fra = wd;
                chk("fra_rd_rdy", {31'b0, rd_rdy_fra}, {31'b0, ers});
                chk("fra_wr_rdy", {31'b0, wr_rdy_fra}, {31'b0, ews});
                if (rd && ers) q_fra.push_back(e);
            end
        endcase
        tick();
        rd_ena_row = 1'b0; wr_ena_row = 1'b0;
        rd_ena_col = 1'b0; wr_ena_col = 1'b0;
        rd_ena_fra = 1'b0; wr_ena_fra = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_vld_row) begin
            if (q_row.size() == 0) chk("row_unexpected_vld", 32'd1, 32'd0);
            else begin
                e = q_row.pop_front();
                chk("row_rd_dat", rd_dat_row, e.dat);
                chk("row_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (rd_vld_col) begin
            if (q_col.size() == 0) chk("col_unexpected_vld", 32'd1, 32'd0);
            else begin
                e = q_col.pop_front();
                chk("col_rd_dat", rd_dat_col, e.dat);
                chk("col_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (rd_vld_fra) begin
            if (q_fra.size() == 0) chk("fra_unexpected_vld", 32'd1, 32'd0);
            else begin
                e = q_fra.pop_front();
                chk("fra_rd_dat", rd_dat_fra, e.dat);
                chk("fra_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; sel = 2'd0;
        wr_ena_row = 0; wr_ena_col = 0; wr_ena_fra = 0;
        rd_ena_row = 0; rd_ena_col = 0; rd_ena_fra = 0;
        wr_adr_row = '0; wr_adr_col = '0; wr_adr_fra = '0;
        wr_dat_row = '0; wr_dat_col = '0; wr_dat_fra = '0;
        rd_adr_row = '0; rd_adr_col = '0; rd_adr_fra = '0;
        idle_cyc(3);
        chk("rst_wr_rdy", {29'b0, wr_rdy_row, wr_rdy_col, wr_rdy_fra}, 32'h7);
        chk("rst_rd_rdy", {29'b0, rd_rdy_row, rd_rdy_col, rd_rdy_fra}, 32'h7);
        chk("rst_rd_vld", {29'b0, rd_vld_row, rd_vld_col, rd_vld_fra}, 32'h0);
        chk("rst_rd_dat", rd_dat_row | rd_dat_col | rd_dat_fra, 32'h0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        rstn = 1'b1;
        idle_cyc(2);

        // Basic posted write, drain and SRAM read; rd_dat must hold afterwards.
        sel = 2'd0;
        step(0, 0, 0, 0, 1, 12'h15, 32'hA1B2C3D4, 1, 1);
        chk("t1_idle_busy", {31'b0, idle}, 32'd0);
        idle_cyc(3);
        step(0, 1, 12'h15, 32'hA1B2C3D4, 0, 0, 0, 1, 1);
        idle_cyc(3);
        chk("t1_rd_dat_hold", rd_dat_row, 32'hA1B2C3D4);
        chk("t1_idle", {31'b0, idle}, 32'd1);

        // U and V planes at the same logical address land in distinct physical words.
        sel = 2'd1;
        step(1, 0, 0, 0, 1, 12'hFF, 32'h11223344, 1, 1);
        sel = 2'd2;
        step(1, 0, 0, 0, 1, 12'hFF, 32'h55667788, 1, 1);
        idle_cyc(3);
        sel = 2'd1;
        step(1, 1, 12'hFF, 32'h11223344, 0, 0, 0, 1, 1);
        sel = 2'd2;
        step(1, 1, 12'hFF, 32'h55667788, 0, 0, 0, 1, 1);

        // Same-cycle write is invisible to the read; the next read forwards it.
        sel = 2'd0;
        step(0, 0, 0, 0, 1, 12'h20, 32'h0BADF00D, 1, 1);
        idle_cyc(3);
        step(0, 1, 12'h20, 32'h0BADF00D, 1, 12'h20, 32'hDEAD0001, 1, 1);
        step(0, 1, 12'h20, 32'hDEAD0001, 0, 0, 0, 1, 1);
        idle_cyc(3);
        step(0, 1, 12'h20, 32'hDEAD0001, 0, 0, 0, 1, 1);

        // Continuous fra reads fill the buffer; one stalled cycle drains the head.
        step(2, 0, 0, 0, 1, 12'h100, 32'h0000100A, 1, 1);
        idle_cyc(3);
        step(2, 1, 12'h100, 32'h0000100A, 1, 12'h010, 32'hF0F00010, 1, 1);
        step(2, 1, 12'h100, 32'h0000100A, 1, 12'h011, 32'hF0F00011, 1, 1);
        step(2, 1, 12'h100, 32'h0, 0, 0, 0, 0, 0);
        step(2, 1, 12'h010, 32'hF0F00010, 0, 0, 0, 1, 1);
        step(2, 1, 12'h011, 32'hF0F00011, 0, 0, 0, 1, 1);
        idle_cyc(3);
        step(2, 1, 12'h011, 32'hF0F00011, 0, 0, 0, 1, 1);

        // Two writes to one address: the younger value is the one returned.
        step(2, 1, 12'h100, 32'h0000100A, 1, 12'h040, 32'h1, 1, 1);
        step(2, 1, 12'h100, 32'h0000100A, 1, 12'h040, 32'h2, 1, 1);
        step(2, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2, 1, 12'h040, 32'h2, 1, 12'h040, 32'h3, 1, 1);
        step(2, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2, 1, 12'h040, 32'h3, 0, 0, 0, 1, 1);
        idle_cyc(3);
        step(2, 1, 12'h040, 32'h3, 0, 0, 0, 1, 1);

        // Reserved plane select maps every address to physical word 0.
        sel = 2'd3;
        step(0, 0, 0, 0, 1, 12'h55, 32'h33333333, 1, 1);
        idle_cyc(3);
        sel = 2'd0;
        step(0, 1, 12'h00, 32'h33333333, 0, 0, 0, 1, 1);
        idle_cyc(2);

        // Asynchronous reset with two pending writes and a read in flight.
        step(2, 1, 12'h100, 32'h0000100A, 1, 12'h080, 32'hAAAA0080, 1, 1);
        rd_ena_fra = 1'b1; rd_adr_fra = 12'h100;
        wr_ena_fra = 1'b1; wr_adr_fra = 12'h081; wr_dat_fra = 32'hAAAA0081;
        tick();
        rd_ena_fra = 1'b0; wr_ena_fra = 1'b0;
        chk("t6_pre_vld", {31'b0, rd_vld_fra}, 32'd1);
        chk("t6_pre_full", {30'b0, wr_rdy_fra, rd_rdy_fra}, 32'd0);
        chk("t6_pre_idle", {31'b0, idle}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("t6_wr_rdy", {31'b0, wr_rdy_fra}, 32'd1);
        chk("t6_rd_rdy", {31'b0, rd_rdy_fra}, 32'd1);
        chk("t6_rd_vld", {31'b0, rd_vld_fra}, 32'd0);
        chk("t6_rd_dat", rd_dat_fra, 32'h0);
        chk("t6_idle", {31'b0, idle}, 32'd1);
        idle_cyc(2);
        rstn = 1'b1;
        idle_cyc(2);

        step(0, 0, 0, 0, 1, 12'h33, 32'hC0FFEE33, 1, 1);
        idle_cyc(3);
        step(0, 1, 12'h33, 32'hC0FFEE33, 0, 0, 0, 1, 1);
        idle_cyc(4);

        chk("row_pending_reads", 32'(q_row.size()), 32'd0);
        chk("col_pending_reads", 32'(q_col.size()), 32'd0);
        chk("fra_pending_reads", 32'(q_fra.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/intra_ref_buf_arb.md
Name: intra_ref_buf_arb

Overview:
- Parametrised next-generation intra reference-pixel buffer: three single-port SRAM banks (row, col, frame) with Y/U/V plane address remapping.
- Unlike the previous wrapper, writes are posted into a per-bank write buffer, so a read and a write in the same cycle never collide.
- A read that hits a pending write is forwarded from the buffer, and a full buffer applies backpressure.
- Sits between intra reconstruction writeback and intra reference fetch.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel
- PIX_PER_WORD, 4, pixels per SRAM word (DW = PIXEL_WIDTH*PIX_PER_WORD)
- RC_ADR_W, 8, row/col logical address width
- FRA_ADR_W, 12, frame logical address width (PIC_X_WIDTH+4)
- WBUF_DEPTH, 2, posted-write entries per bank (>=1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- sel_i  in  2  plane select: `TYPE_Y / `TYPE_U / `TYPE_V
- wr_ena_{row,col,fra}_i  in  1  write request per bank
- wr_rdy_{row,col,fra}_o  out  1  bank write buffer can accept
- wr_adr_{row,col}_i / wr_adr_fra_i  in  RC_ADR_W / FRA_ADR_W  write address
- wr_dat_{row,col,fra}_i  in  DW  write data
- rd_ena_{row,col,fra}_i  in  1  read request
- rd_rdy_{row,col,fra}_o  out  1  read can be accepted this cycle
- rd_adr_{row,col}_i / rd_adr_fra_i  in  RC_ADR_W / FRA_ADR_W  read address
- rd_dat_{row,col,fra}_o  out  DW  read data
- rd_vld_{row,col,fra}_o  out  1  rd_dat valid pulse
- idle_o  out  1  all write buffers empty

Behaviour:
- Remap (per bank, A = logical width; identical for rd and wr):
  - Y -> {1'b0, adr}
  - U -> {3'b100, adr[A-3:0]}
  - V -> {3'b101, adr[A-3:0]}
  - sel 2'b11 -> physical 0
  - Remap is applied at accept time; the buffer stores physical addresses, so sel may change while writes are pending.
- Each bank is independent and identical. SRAM is single-port, width DW, depth 2^(A+1), 1-cycle registered read.
- Write accept: wr_ena & wr_rdy. wr_rdy = (count < WBUF_DEPTH), computed from the registered count only. A write with wr_rdy low is ignored; upstream holds the request.
- Port arbitration each cycle:
  - count==WBUF_DEPTH: drain head to SRAM; rd_rdy=0.
  - else if rd_ena: SRAM read; rd_rdy=1.
  - else if count>0: drain head.
- Simultaneous accept and drain: count unchanged; FIFO order preserved.
- Forwarding:
  - An accepted read whose physical address matches any valid entry returns the data of the youngest match; SRAM is not read (port idle or draining).
  - A write accepted in the same cycle is not visible to that read.
- Read latency: rd_vld pulses exactly 1 cycle after accept.
  - rd_dat = SRAM output, or the forwarded data registered at accept.
  - rd_dat holds its last value until the next rd_vld.
- A drained entry becomes SRAM-visible to reads accepted from the next cycle onward.
- idle_o = all three counts zero (registered).
- Reset values: counts 0, all entries invalid, wr_rdy=1, rd_rdy=1, rd_vld=0, rd_dat=0, idle_o=1. Reset mid-operation discards pending writes; SRAM contents are unspecified.

Test Plan:
1. Reset, sel=Y, write row adr 0x15 data 0xA1B2C3D4, wait 3 cycles, read 0x15 -> rd_vld 1 cycle later, rd_dat=0xA1B2C3D4, idle_o=1.
2. sel=U, write col adr 0xFF data 0x11223344, then sel=V, write col 0xFF data 0x55667788. Read both back with matching sel -> distinct data (physical 0x13F vs 0x17F).
3. Same-cycle write row 0x20=0xDEAD0001 and read row 0x20 (empty buffer) -> old SRAM value returned. Read 0x20 next cycle -> forwarded 0xDEAD0001.
4. Continuous reads on fra with 2 writes queued (WBUF_DEPTH=2) -> rd_rdy drops one cycle, head drained, wr_rdy returns to 1 next cycle; all writes later readable.
5. Two pending writes to fra 0x040 (0x1, then 0x2) -> read 0x040 returns 0x2.
6. Assert rstn=0 with 2 pending writes -> wr_rdy=1, rd_vld=0, rd_dat=0, idle_o=1 immediately (asynchronous).
